// File: rtl/lm32_stream_fifo_pkg.sv
// ============================================================================
// lm32_stream_fifo_pkg
// Shared defaults and per-cycle control decode type for lm32_stream_fifo.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package lm32_stream_fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  // Per-cycle decisions derived from registered state and the two strobes.
  typedef struct packed {
    logic full;
    logic push_ok;
    logic push_rej;
    logic pop;
    logic load;
  } fifo_ctl_t;

  // Occupancy step selected by simultaneous push/load.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_step_e;

  function automatic cnt_step_e count_step(input logic push_ok, input logic load);
    case ({push_ok, load})
      2'b10:   count_step = CNT_INC;
      2'b01:   count_step = CNT_DEC;
      default: count_step = CNT_HOLD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lm32_stream_fifo_dp_ram.sv
// ============================================================================
// lm32_stream_fifo_dp_ram
// Dual-port RAM (the lm32_dp_ram role): one write port, one registered-read port.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module lm32_stream_fifo_dp_ram #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write-first on an address collision so a word pushed into an empty FIFO
  // is already on the read port the following cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/lm32_stream_fifo.sv
// ============================================================================
// lm32_stream_fifo
// FWFT FIFO over a dual-port RAM with a registered valid/ready output stage.
// Optional build macro: CFG_FIFO_LEVEL_EN (drives level_o; otherwise tied 0).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module lm32_stream_fifo
  import lm32_stream_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  full_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH+1:0] level_o,
  output logic                  overflow_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;

  fifo_ctl_t             ctl;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    ctl          = '0;
    ctl.full     = (ram_count_q == C_FULL_COUNT);
    ctl.push_ok  = push_i & ~ctl.full;
    ctl.push_rej = push_i & ctl.full;
    ctl.pop      = out_valid_q & out_ready_i;
    ctl.load     = (ram_count_q != '0) & (~out_valid_q | ctl.pop);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;

    if (ctl.push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (ctl.load) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case (count_step(ctl.push_ok, ctl.load))
      CNT_INC: ram_count_d = ram_count_q + 1'b1;
      CNT_DEC: ram_count_d = ram_count_q - 1'b1;
      default: ram_count_d = ram_count_q;
    endcase

    if (ctl.load) begin
      out_data_d  = ram_rdata;
      out_valid_d = 1'b1;
    end else if (ctl.pop) begin
      out_valid_d = 1'b0;
    end

    if (ctl.push_rej) begin
      overflow_d = 1'b1;
    end
  end

  // Read address is the next rd_ptr, so the RAM output tracks the head one
  // cycle later; during reset it follows the cleared pointer instead.
  assign ram_we    = ctl.push_ok & rst_i;
  assign ram_raddr = rst_i ? rd_ptr_d : '0;

  lm32_stream_fifo_dp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_data_i),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign full_o      = ctl.full;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign overflow_o  = overflow_q;

`ifdef CFG_FIFO_LEVEL_EN
  assign level_o = {1'b0, ram_count_q} + {{(ADDR_WIDTH+1){1'b0}}, out_valid_q};
`else
  assign level_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/lm32_stream_fifo.md
# lm32_stream_fifo

Synchronous first-word-fall-through FIFO that owns both ports of an `lm32_dp_ram` and drains its read side into a registered valid/ready output stage. Producers push words without backpressure handshaking (they observe `full_o`); consumers pop with a standard valid/ready handshake. It sits between LM32 peripheral producers (DMA, UART/CSR capture) and downstream stream consumers that require a registered data output.

## Interface
- `addr_width`, 4: log2 of RAM depth; RAM holds 2^addr_width words.
- `data_width`, 32: word width.

- `clk_i`  in  1  system clock; all state updates on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-low.
- `push_i`  in  1  write strobe; accepted when `full_o`=0.
- `push_data_i`  in  data_width  word to write.
- `full_o`  out  1  RAM occupancy == 2^addr_width.
- `out_valid_o`  out  1  output register holds a word.
- `out_data_o`  out  data_width  registered head word.
- `out_ready_i`  in  1  consumer accepts `out_data_o` this cycle.
- `level_o`  out  addr_width+2  total words held (RAM + output register).
- `overflow_o`  out  1  sticky: a push was attempted while full.

## Operation
- State: `wr_ptr`, `rd_ptr` (addr_width bits, natural wrap at 2^addr_width), `ram_count` (addr_width+1 bits), output register + `out_valid_o`, sticky `overflow_o`.
- Push: `push_i`=1 and `full_o`=0 -> RAM write at `wr_ptr`, `wr_ptr`+1, `ram_count`+1. Push while full -> no write, pointers unchanged, `overflow_o` set to 1.
- Pop: `out_valid_o`=1 and `out_ready_i`=1 -> word consumed this edge.
- Load: `ram_count`!=0 and (`out_valid_o`=0 or pop) -> output register <= RAM head, `rd_ptr`+1, `ram_count`-1, `out_valid_o` stays/becomes 1. Pop with no load -> `out_valid_o` <= 0.
- RAM read address is `rd_ptr` next value (`rd_ptr`+1 when loading, else `rd_ptr`), so RAM read data always presents current head one cycle later.
- Simultaneous push and load in one cycle: `ram_count` unchanged; both pointers advance.
- Empty RAM, push at `wr_ptr`==`rd_ptr`: write and registered read address coincide; head visible next cycle (write completes before read).
- Reset (any time, including mid-stream): `wr_ptr`=`rd_ptr`=0, `ram_count`=0, `out_valid_o`=0, `out_data_o`=0, `overflow_o`=0, `full_o`=0, `level_o`=0. RAM contents not cleared; considered discarded.
- `out_data_o` holds stable while `out_valid_o`=1 and `out_ready_i`=0.

## Timing
- Push in cycle N into empty FIFO -> `out_valid_o`=1 in cycle N+2.
- Sustained throughput: one word per cycle with `out_ready_i` held 1 and continuous pushes.
- `full_o`, `level_o` are registered-state derived; update the cycle after the causing edge. Total capacity 2^addr_width+1 words.
- `overflow_o` asserts the cycle after the rejected push; clears only on reset.

## Configuration
- `CFG_FIFO_LEVEL_EN`: defined -> `level_o` = `ram_count` + `out_valid_o`, combinational from registers. Undefined -> `level_o` tied to 0 and adder removed; all other behaviour identical.

## Structure
- Shared header (`lm32_include.v`): `CFG_FIFO_LEVEL_EN` default, any shared width macros.
- One sub-module: `lm32_dp_ram` instantiated with `addr_width`, `data_width`; write port from push logic, read port from load logic. All control in this block.

## Test plan
- Reset, push 0xA5A5A5A5 at cycle 0, `out_ready_i`=0 -> `out_valid_o`=1 at cycle 2, data 0xA5A5A5A5, held stable 10 cycles.
- addr_width=4: push 18 words 1..18 with `out_ready_i`=0 -> 17 accepted, `full_o`=1, `overflow_o`=1 after 18th; pop all -> order 1..17.
- Continuous push 0..99 with `out_ready_i`=1 -> outputs 0..99 consecutive cycles, no gaps after initial 2-cycle latency, `level_o` ≤ 2.
- Random `out_ready_i` (50%) with random push -> scoreboard match, pointer wrap exercised ≥ 3 times, `overflow_o`=0.
- Reset asserted with 9 words held -> next cycle `out_valid_o`=0, `level_o`=0, `full_o`=0; new push 0x1 emerges first.
- Build without `CFG_FIFO_LEVEL_EN` -> `level_o`=0 throughout; data scenarios identical.
